// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate-cell BIST sequencer.
// Truth tables are indexed by {a,b}; bit i is the expected y for a=i[1], b=i[0].
package gate_test_pkg;

    localparam int MAX_SETTLE = 15;

    localparam logic [3:0] TRUTH_NOR  = 4'b0001;
    localparam logic [3:0] TRUTH_NAND = 4'b0111;
    localparam logic [3:0] TRUTH_AND  = 4'b1000;
    localparam logic [3:0] TRUTH_OR   = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Control, GUT-drive and result signals between the BIST sequencer and its user.
// master drives start/abort and returns the GUT output; slave is the sequencer.
interface gate_bist_ctrl_if;
    logic       start;
    logic       abort;
    logic       a_out;
    logic       b_out;
    logic       y_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;

    modport master (
        output start, abort, y_in,
        input  a_out, b_out, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        input  start, abort, y_in,
        output a_out, b_out, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/gate_bist_settle_timer.sv
// Loadable 4-bit down-counter timing how long each vector is held on the GUT.
// Load takes priority over decrement; decrement saturates at zero.
module gate_bist_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic [3:0] o_value,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == 4'd0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for one 2-input gate: walks {a,b} through 00..11, holds each SETTLE_CYCLES,
// samples y and accumulates a failure map; done pulses 4*(SETTLE_CYCLES+1) cycles after start.
module gate_bist_ctrl
    import gate_test_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] TRUTH         = TRUTH_NOR
) (
    input  logic             clk,
    input  logic             rst,
    gate_bist_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETTLE = ST_SETTLE;
    localparam logic [1:0] S_SAMPLE = ST_SAMPLE;
    localparam logic [1:0] S_DONE   = ST_DONE;
    localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > MAX_SETTLE)) begin : g_bad_settle
        $error("gate_bist_ctrl: SETTLE_CYCLES must lie in 1..15");
    end

    logic [1:0] r_state;
    logic [1:0] r_idx;
    logic       r_a;
    logic       r_b;
    logic       r_pass;
    logic [2:0] r_err_cnt;
    logic [3:0] r_fail_vec;

    logic       w_go;
    logic       w_reload;
    logic       w_load;
    logic       w_dec;
    logic       w_zero;
    logic [3:0] w_value;
    logic       w_mismatch;
    logic [3:0] w_fail_next;

    assign w_go     = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_reload = (r_state == S_SAMPLE) && !bus.abort && (r_idx != 2'd3);
    assign w_load   = w_go || w_reload;
    assign w_dec    = (r_state == S_SETTLE);

    // Case inequality so an undriven or X output on the GUT is a failure, never a pass.
    assign w_mismatch  = (bus.y_in !== TRUTH[r_idx]);
    assign w_fail_next = r_fail_vec | (w_mismatch ? (4'b0001 << r_idx) : 4'b0000);

    gate_bist_settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .o_value    (w_value),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 3'd0;
            r_fail_vec <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state    <= S_SETTLE;
                        r_idx      <= 2'd0;
                        r_a        <= 1'b0;
                        r_b        <= 1'b0;
                        r_pass     <= 1'b0;
                        r_err_cnt  <= 3'd0;
                        r_fail_vec <= 4'd0;
                    end
                end
                S_SETTLE: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (w_zero) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    // An abort in the sample cycle throws the sample away.
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (w_mismatch) begin
                            r_fail_vec <= w_fail_next;
                            r_err_cnt  <= r_err_cnt + 3'd1;
                        end
                        if (r_idx == 2'd3) begin
                            r_state <= S_DONE;
                            r_pass  <= (w_fail_next == 4'd0);
                        end else begin
                            r_idx        <= r_idx + 2'd1;
                            {r_a, r_b}   <= r_idx + 2'd1;
                            r_state      <= S_SETTLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.a_out    = r_a;
    assign bus.b_out    = r_b;
    assign bus.busy     = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.pass     = r_pass;
    assign bus.err_cnt  = r_err_cnt;
    assign bus.fail_vec = r_fail_vec;

    a_timer_range: assert property (@(posedge clk) disable iff (rst) w_value <= LOAD_VAL);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: a NOR instance (settle 2) and a NAND instance (settle 1),
// checked every cycle against a time-arithmetic model plus hand-computed run results.
module tb_gate_bist_ctrl;
    import gate_test_pkg::*;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   mode0;      // 0 good NOR, 1 y tied 0, 2 y tied 1, 3 y unknown
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    gate_bist_ctrl_if bus0 ();
    gate_bist_ctrl_if bus1 ();

    assign bus0.y_in = (mode0 == 0) ? ~(bus0.a_out | bus0.b_out) :
                       (mode0 == 1) ? 1'b0 :
                       (mode0 == 2) ? 1'b1 : 1'bx;
    assign bus1.y_in = ~(bus1.a_out & bus1.b_out);

    gate_bist_ctrl #(.SETTLE_CYCLES(2), .TRUTH(TRUTH_NOR)) u_dut0 (
        .clk (clk), .rst (rst0), .bus (bus0.slave)
    );
    gate_bist_ctrl #(.SETTLE_CYCLES(1), .TRUTH(TRUTH_NAND)) u_dut1 (
        .clk (clk), .rst (rst1), .bus (bus1.slave)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is a timeline of 4 slots of (S+1) cycles, the last cycle of each slot samples y.
    bit         m_run  [2];
    bit         m_done [2];
    bit         m_pass [2];
    int         m_t    [2];
    int         m_cnt  [2];
    int         m_vec  [2];
    logic [3:0] m_fail [2];
    int         m_s    [2] = '{2, 1};
    logic [3:0] m_tr   [2] = '{4'b0001, 4'b0111};

    task automatic model_step(input int i, input logic r, input logic st, input logic ab,
                              input logic y);
        int ph, v;
        logic [3:0] tr;
        if (r) begin
            m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0;
            m_cnt[i] = 0; m_vec[i] = 0; m_fail[i] = 4'd0;
            return;
        end
        if (m_done[i]) begin
            m_done[i] = 0;
            return;
        end
        if (!m_run[i]) begin
            if (st && !ab) begin
                m_run[i] = 1; m_t[i] = 1; m_pass[i] = 0;
                m_cnt[i] = 0; m_vec[i] = 0; m_fail[i] = 4'd0;
            end
            return;
        end
        if (ab) begin
            m_run[i] = 0;
            return;
        end
        ph = (m_t[i] - 1) % (m_s[i] + 1);
        v  = (m_t[i] - 1) / (m_s[i] + 1);
        tr = m_tr[i];
        if (ph == m_s[i]) begin
            if (y !== tr[v]) begin
                m_fail[i][v] = 1'b1;
                m_cnt[i]++;
            end
            if (v == 3) begin
                m_run[i]  = 0;
                m_done[i] = 1;
                m_pass[i] = (m_cnt[i] == 0);
            end else begin
                m_vec[i] = v + 1;
            end
        end
        m_t[i]++;
    endtask

    always @(posedge clk) begin
        model_step(0, rst0, bus0.start, bus0.abort, bus0.y_in);
        model_step(1, rst1, bus1.start, bus1.abort, bus1.y_in);
    end

    function automatic logic [15:0] model_pack(input int i);
        return {4'd0, m_run[i], m_done[i], m_pass[i], 3'(m_cnt[i]), m_fail[i], 2'(m_vec[i])};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle_nor", {4'd0, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt,
                              bus0.fail_vec, bus0.a_out, bus0.b_out}, model_pack(0));
            chk("cycle_nand", {4'd0, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt,
                               bus1.fail_vec, bus1.a_out, bus1.b_out}, model_pack(1));
        end
    end

    task automatic set_start(input int i, input logic v);
        if (i == 0) bus0.start = v; else bus1.start = v;
    endtask

    function automatic logic get_done(input int i);
        return (i == 0) ? bus0.done : bus1.done;
    endfunction

    // Start is presented in cycle 0; returns the cycle number in which done was seen.
    task automatic run(input int i, output int dcyc);
        set_start(i, 1'b1);
        @(negedge clk);
        set_start(i, 1'b0);
        dcyc = 1;
        while (!get_done(i) && dcyc < 100) begin
            @(negedge clk);
            dcyc++;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus0.done) n++;
        end
    endtask

    initial begin
        int d, nd;
        rst0 = 1'b1; rst1 = 1'b1; mode0 = 0;
        bus0.start = 1'b0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_outputs", {bus0.busy, bus0.done, bus0.pass, bus0.err_cnt, bus0.fail_vec,
                              bus0.a_out, bus0.b_out}, 16'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // Good NOR cell
        run(0, d);
        chk("nor_done_cycle", d, 13);
        chk("nor_pass", bus0.pass, 1);
        chk("nor_err_cnt", bus0.err_cnt, 0);
        chk("nor_fail_vec", bus0.fail_vec, 4'b0000);
        bus0.start = 1'b1;                 // start during DONE is ignored
        @(negedge clk);
        bus0.start = 1'b0;
        chk("start_in_done_busy", bus0.busy, 0);
        chk("nor_pass_holds", bus0.pass, 1);

        // y stuck at 0
        mode0 = 1;
        run(0, d);
        chk("tie0_done_cycle", d, 13);
        chk("tie0_pass", bus0.pass, 0);
        chk("tie0_err_cnt", bus0.err_cnt, 1);
        chk("tie0_fail_vec", bus0.fail_vec, 4'b0001);
        chk("last_vector_held", {bus0.a_out, bus0.b_out}, 2'b11);
        @(negedge clk);

        // y stuck at 1
        mode0 = 2;
        run(0, d);
        chk("tie1_err_cnt", bus0.err_cnt, 3);
        chk("tie1_fail_vec", bus0.fail_vec, 4'b1110);
        @(negedge clk);

        // y unknown: outcome tracked by the per-cycle model
        mode0 = 3;
        run(0, d);
        chk("unknown_done_cycle", d, 13);
        chk("unknown_pass", bus0.pass, 0);
        repeat (4) @(negedge clk);

        // NAND instance with settle 1
        run(1, d);
        chk("nand_done_cycle", d, 9);
        chk("nand_pass", bus1.pass, 1);
        chk("nand_fail_vec", bus1.fail_vec, 4'b0000);
        @(negedge clk);

        // start together with abort in IDLE
        mode0 = 1;
        bus0.start = 1'b1; bus0.abort = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0; bus0.abort = 1'b0;
        chk("start_abort_idle", bus0.busy, 0);

        // restart at cycle 5 ignored, abort at cycle 7
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (4) @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        @(negedge clk);
        chk("busy_before_abort", bus0.busy, 1);
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        chk("abort_busy_drop", bus0.busy, 0);
        chk("abort_err_cnt", bus0.err_cnt, 1);
        chk("abort_fail_vec", bus0.fail_vec, 4'b0001);
        chk("abort_pass", bus0.pass, 0);
        count_done(20, nd);
        chk("abort_no_done", nd, 0);
        mode0 = 0;
        run(0, d);
        chk("after_abort_done_cycle", d, 13);
        chk("after_abort_pass", bus0.pass, 1);
        @(negedge clk);

        // reset during the sample of vector 2 (cycle 9)
        mode0 = 1;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_vector", {bus0.a_out, bus0.b_out}, 2'b10);
        chk("pre_reset_err", bus0.err_cnt, 1);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("midrun_reset_outputs", {bus0.busy, bus0.done, bus0.pass, bus0.err_cnt,
                                     bus0.fail_vec, bus0.a_out, bus0.b_out}, 16'd0);
        count_done(20, nd);
        chk("reset_no_done", nd, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule
